// File: rtl/pixel_shadow_reader.sv
// pixel_shadow_reader
// -------------------
// Keeps a 3-bit-per-pixel shadow copy of a framebuffer by snooping plot
// writes. A single-outstanding read port returns the colour at (rd_x, rd_y).
// A clear operation fills the whole shadow buffer with black (colour 0).
//
// Optional feature: define PIXEL_SHADOW_DROP_CNT_EN to add the drop_count
// output. It is a saturating count of plots that were dropped because they
// were out of range or arrived while a clear was running.
//
// Ports
//   clock       : rising-edge clock
//   reset       : asynchronous active-high reset (starts a clear)
//   wr_x/wr_y   : snooped plot coordinates
//   wr_colour   : snooped plot colour
//   wr_plot     : plot strobe, one pixel per clock while high
//   rd_req      : read request, accepted when rd_ready is high
//   rd_x/rd_y   : read coordinates
//   rd_ready    : high only while idle
//   rd_valid    : one-clock response pulse
//   rd_colour   : read colour, held until the next response
//   rd_oob      : response was for out-of-range coordinates
//   clear_req   : start filling the buffer with black
//   busy        : high while a clear is in progress
//   drop_count  : (optional) saturating dropped-plot counter
module pixel_shadow_reader #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] wr_x,
    input  logic [7:0] wr_y,
    input  logic [2:0] wr_colour,
    input  logic       wr_plot,
    input  logic       rd_req,
    input  logic [7:0] rd_x,
    input  logic [7:0] rd_y,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [2:0] rd_colour,
    output logic       rd_oob,
    input  logic       clear_req,
    output logic       busy
`ifdef PIXEL_SHADOW_DROP_CNT_EN
    ,
    output logic [7:0] drop_count
`endif
);

    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [14:0] WIDTH_V   = 15'(WIDTH);
    localparam logic [8:0]  WIDTH_L   = 9'(WIDTH);
    localparam logic [8:0]  HEIGHT_L  = 9'(HEIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // y*WIDTH + x as a shift-and-add over the set bits of the constant
    // WIDTH; for the default 160 this reduces to (y<<7)+(y<<5)+x.
    function automatic logic [14:0] pixel_addr(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] acc;
        acc = {7'd0, x};
        for (int i = 0; i < 15; i++) begin
            if (WIDTH_V[i]) begin
                acc = acc + ({7'd0, y} << i);
            end
        end
        return acc;
    endfunction

    state_t      state_r;
    logic [14:0] clear_addr_r;
    logic [14:0] rd_addr_r;
    logic        rd_oob_pend_r;
    logic [2:0]  mem_r [0:DEPTH-1];

    logic        wr_in_range_s;
    logic        plot_ok_s;
    logic [14:0] wr_addr_s;
    logic        rd_in_range_s;
    logic [14:0] rd_req_addr_s;
    logic        mem_we_s;
    logic [14:0] mem_waddr_s;
    logic [2:0]  mem_wdata_s;
    logic [2:0]  mem_rdata_s;
    logic        bypass_s;

    // Address decode, plot qualification and the shared memory write port.
    always_comb begin
        wr_in_range_s = ({1'b0, wr_x} < WIDTH_L) && ({1'b0, wr_y} < HEIGHT_L);
        rd_in_range_s = ({1'b0, rd_x} < WIDTH_L) && ({1'b0, rd_y} < HEIGHT_L);
        wr_addr_s     = pixel_addr(wr_x, wr_y);
        rd_req_addr_s = pixel_addr(rd_x, rd_y);
        plot_ok_s     = wr_plot && wr_in_range_s && (state_r != CLEAR);
        mem_rdata_s   = mem_r[rd_addr_r];
        // A plot landing on the pending read address in the READ clock is
        // only visible in memory after this edge, so forward it directly.
        bypass_s      = plot_ok_s && (wr_addr_s == rd_addr_r);
        if (state_r == CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clear_addr_r;
            mem_wdata_s = 3'd0;
        end else begin
            mem_we_s    = plot_ok_s;
            mem_waddr_s = wr_addr_s;
            mem_wdata_s = wr_colour;
        end
    end

    // Shadow framebuffer storage; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= CLEAR;
            clear_addr_r  <= 15'd0;
            rd_addr_r     <= 15'd0;
            rd_oob_pend_r <= 1'b0;
            rd_ready      <= 1'b0;
            rd_valid      <= 1'b0;
            rd_colour     <= 3'd0;
            rd_oob        <= 1'b0;
            busy          <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    rd_valid <= 1'b0;
                    if (clear_req) begin
                        state_r      <= CLEAR;
                        clear_addr_r <= 15'd0;
                        busy         <= 1'b1;
                        rd_ready     <= 1'b0;
                    end else if (rd_req) begin
                        state_r       <= READ;
                        rd_oob_pend_r <= !rd_in_range_s;
                        rd_ready      <= 1'b0;
                        // Out-of-range reads never touch memory; keep the
                        // previous address so no bogus index is formed.
                        if (rd_in_range_s) begin
                            rd_addr_r <= rd_req_addr_s;
                        end
                    end
                end
                CLEAR: begin
                    clear_addr_r <= clear_addr_r + 15'd1;
                    if (clear_addr_r == LAST_ADDR) begin
                        state_r  <= IDLE;
                        busy     <= 1'b0;
                        rd_ready <= 1'b1;
                    end
                end
                READ: begin
                    state_r  <= RESP;
                    rd_valid <= 1'b1;
                    rd_oob   <= rd_oob_pend_r;
                    if (rd_oob_pend_r) begin
                        rd_colour <= 3'd0;
                    end else if (bypass_s) begin
                        rd_colour <= wr_colour;
                    end else begin
                        rd_colour <= mem_rdata_s;
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    rd_valid <= 1'b0;
                    rd_ready <= 1'b1;
                end
                default: begin
                    state_r  <= IDLE;
                    rd_valid <= 1'b0;
                    rd_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIXEL_SHADOW_DROP_CNT_EN
    logic drop_s;

    // A plot is dropped when it is strobed but not written to memory.
    always_comb begin
        drop_s = wr_plot && !plot_ok_s;
    end

    // Saturating dropped-plot counter, zeroed whenever a clear starts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if ((state_r == IDLE) && clear_req) begin
            drop_count <= 8'd0;
        end else if (drop_s && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule
